// File: rtl/tape_pkg.sv
// rtl/tape_pkg.sv - symbol codes, FSM states and symbol conversion helpers
// Shared by tape_head and tape_mem: 2-bit cell codes, READY/SETTLE states,
// one-hot <-> code conversion.
package tape_pkg;

    localparam logic [1:0] SYM_BLANK = 2'd0;
    localparam logic [1:0] SYM_S1    = 2'd1;
    localparam logic [1:0] SYM_S2    = 2'd2;

    typedef enum logic {
        READY  = 1'b0,
        SETTLE = 1'b1
    } state_e;

    typedef struct packed {
        logic       invalid;
        logic [1:0] code;
    } sym_enc_t;

    // Anything that is not exactly one-hot is stored as blank and flagged.
    function automatic sym_enc_t sym_encode(input logic [2:0] onehot);
        sym_enc_t r;
        r.invalid = 1'b0;
        r.code    = SYM_BLANK;
        case (onehot)
            3'b001:  r.code = SYM_BLANK;
            3'b010:  r.code = SYM_S1;
            3'b100:  r.code = SYM_S2;
            default: r.invalid = 1'b1;
        endcase
        return r;
    endfunction

    // Code 3 never gets stored; it decodes to blank for safety.
    function automatic logic [2:0] sym_decode(input logic [1:0] code);
        logic [2:0] r;
        case (code)
            SYM_S1:  r = 3'b010;
            SYM_S2:  r = 3'b100;
            default: r = 3'b001;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tape_mem.sv
// rtl/tape_mem.sv - tape cell array, one sync write port, one async read port
// Ports: clk, rst_n (async, active-low, clears all cells to blank),
//        we_i/wdata_i write the cell at addr_i; rdata_o is cell[addr_i].
module tape_mem
    import tape_pkg::*;
#(
    parameter int TAPE_LEN = 16,
    parameter int PTR_W    = $clog2(TAPE_LEN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we_i,
    input  logic [PTR_W-1:0] addr_i,
    input  logic [1:0]       wdata_i,
    output logic [1:0]       rdata_o
);

    logic [1:0] cells_q [TAPE_LEN];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPE_LEN; i++) begin
                cells_q[i] <= SYM_BLANK;
            end
        end else if (we_i) begin
            cells_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = cells_q[addr_i];

endmodule

// File: rtl/tape_head.sv
// rtl/tape_head.sv - Turing machine tape and head: step/load/rewind FSM
// Ports: clk, rst_n (async, active-low); step_valid/write_sym/direction
//        step the machine; load_valid/load_sym fill the tape moving right;
//        rewind homes the head; step_ready, s2/s1/s0 (symbol under head),
//        head_pos, at_left, at_right, fault (sticky until reset).
module tape_head
    import tape_pkg::*;
#(
    parameter int TAPE_LEN = 16,
    parameter int PTR_W    = $clog2(TAPE_LEN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step_valid,
    output logic             step_ready,
    input  logic [2:0]       write_sym,
    input  logic             direction,
    input  logic             load_valid,
    input  logic [2:0]       load_sym,
    input  logic             rewind,
    output logic             s2,
    output logic             s1,
    output logic             s0,
    output logic [PTR_W-1:0] head_pos,
    output logic             at_left,
    output logic             at_right,
    output logic             fault
);

    localparam logic [PTR_W-1:0] HEAD_MAX = PTR_W'(TAPE_LEN - 1);

    state_e           state_q, state_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [2:0]       sym_q, sym_d;
    logic             fault_q, fault_d;

    logic             mem_we;
    logic [1:0]       mem_rdata;
    logic [2:0]       cmd_sym;
    logic             cmd_dir;
    sym_enc_t         enc;

    // A load is a step with the load symbol and a forced right move; when
    // both are requested the step wins, so its operands are selected.
    assign cmd_sym = step_valid ? write_sym : load_sym;
    assign cmd_dir = step_valid ? direction : 1'b1;
    assign enc     = sym_encode(cmd_sym);

    tape_mem #(
        .TAPE_LEN (TAPE_LEN),
        .PTR_W    (PTR_W)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (mem_we),
        .addr_i  (head_q),
        .wdata_i (enc.code),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        sym_d   = sym_q;
        fault_d = fault_q;
        mem_we  = 1'b0;
        case (state_q)
            READY: begin
                if (rewind) begin
                    head_d  = '0;
                    state_d = SETTLE;
                end else if (step_valid || load_valid) begin
                    mem_we  = 1'b1;
                    state_d = SETTLE;
                    if (enc.invalid) begin
                        fault_d = 1'b1;
                    end
                    // At either end the write still lands but the head stays.
                    if (cmd_dir) begin
                        if (head_q == HEAD_MAX) fault_d = 1'b1;
                        else                    head_d  = head_q + PTR_W'(1);
                    end else begin
                        if (head_q == '0) fault_d = 1'b1;
                        else              head_d  = head_q - PTR_W'(1);
                    end
                end
            end
            SETTLE: begin
                // The write from the accept edge is already in the array,
                // so this read sees the new value even on a same-cell return.
                sym_d   = sym_decode(mem_rdata);
                state_d = READY;
            end
            default: state_d = READY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= READY;
            head_q  <= '0;
            sym_q   <= 3'b001;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            sym_q   <= sym_d;
            fault_q <= fault_d;
        end
    end

    assign step_ready   = (state_q == READY);
    assign {s2, s1, s0} = sym_q;
    assign head_pos     = head_q;
    assign at_left      = (head_q == '0);
    assign at_right     = (head_q == HEAD_MAX);
    assign fault        = fault_q;

endmodule

// File: tb/tb_tape_head.sv
// tb/tb_tape_head.sv - self-checking bench for tape_head
module tb_tape_head;

    localparam int N = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       step_valid = 1'b0;
    logic       step_ready;
    logic [2:0] write_sym = 3'b001;
    logic       direction = 1'b0;
    logic       load_valid = 1'b0;
    logic [2:0] load_sym = 3'b001;
    logic       rewind = 1'b0;
    logic       s2, s1, s0;
    logic [3:0] head_pos;
    logic       at_left, at_right, fault;

    tape_head dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .step_valid (step_valid),
        .step_ready (step_ready),
        .write_sym  (write_sym),
        .direction  (direction),
        .load_valid (load_valid),
        .load_sym   (load_sym),
        .rewind     (rewind),
        .s2         (s2),
        .s1         (s1),
        .s0         (s0),
        .head_pos   (head_pos),
        .at_left    (at_left),
        .at_right   (at_right),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    int vec = 0;
    int errs = 0;

    // Reference model: tape as an integer array of symbol indices 0..2.
    int         m_tape [N];
    int         m_head;
    bit         m_fault;
    bit         m_acc;
    logic [2:0] m_sym, m_prev_sym;

    // Observations one cycle after the command edge (inside the settle cycle).
    logic       mid_ready, mid_fault;
    logic [3:0] mid_head;
    logic [2:0] mid_sym;

    wire [2:0] dut_sym = {s2, s1, s0};

    function automatic int onehot_index(input logic [2:0] s);
        for (int b = 0; b < 3; b++) if (s == (3'b001 << b)) return b;
        return -1;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < N; i++) m_tape[i] = 0;
        m_head = 0; m_fault = 0; m_sym = 3'b001;
    endtask

    task automatic m_write(input logic [2:0] s, input bit right);
        int v;
        v = onehot_index(s);
        if (v < 0) begin v = 0; m_fault = 1; end
        m_tape[m_head] = v;
        if (right) begin
            if (m_head == N - 1) m_fault = 1; else m_head++;
        end else begin
            if (m_head == 0) m_fault = 1; else m_head--;
        end
    endtask

    task automatic m_cmd(input bit rw, sv, lv, input logic [2:0] ws,
                         input bit dir, input logic [2:0] ls);
        m_prev_sym = m_sym;
        m_acc = rw | sv | lv;
        if (rw)      m_head = 0;
        else if (sv) m_write(ws, dir);
        else if (lv) m_write(ls, 1'b1);
        if (m_acc) m_sym = 3'(1 << m_tape[m_head]);
    endtask

    task automatic do_reset();
        @(negedge clk); rst_n = 1'b0; m_reset();
        @(negedge clk); rst_n = 1'b1;
    endtask

    // Drive one command for a single cycle, capture the settle-cycle view,
    // then wait out the settle cycle.
    task automatic issue(input bit rw, sv, lv, input logic [2:0] ws,
                         input bit dir, input logic [2:0] ls);
        @(negedge clk);
        rewind = rw; step_valid = sv; load_valid = lv;
        write_sym = ws; direction = dir; load_sym = ls;
        m_cmd(rw, sv, lv, ws, dir, ls);
        @(posedge clk); #1;
        rewind = 0; step_valid = 0; load_valid = 0;
        mid_ready = step_ready; mid_head = head_pos; mid_sym = dut_sym; mid_fault = fault;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        do_reset();
        vec++; if (dut_sym !== 3'b001) begin errs++; $display("FAIL reset_sym got %b exp 001", dut_sym); end
        vec++; if (head_pos !== 4'd0) begin errs++; $display("FAIL reset_head got %0d exp 0", head_pos); end
        vec++; if (step_ready !== 1'b1) begin errs++; $display("FAIL reset_ready got %b exp 1", step_ready); end
        vec++; if (fault !== 1'b0) begin errs++; $display("FAIL reset_fault got %b exp 0", fault); end
        vec++; if ({at_left, at_right} !== 2'b10) begin errs++; $display("FAIL reset_edges got %b exp 10", {at_left, at_right}); end
    endtask

    task automatic test_load_rewind();
        issue(0, 0, 1, 3'b001, 0, 3'b010);
        issue(0, 0, 1, 3'b001, 0, 3'b100);
        issue(0, 0, 1, 3'b001, 0, 3'b001);
        vec++; if (head_pos !== 4'd3) begin errs++; $display("FAIL load_head got %0d exp 3", head_pos); end
        issue(1, 0, 0, 3'b001, 0, 3'b001);
        vec++; if (dut_sym !== 3'b010) begin errs++; $display("FAIL rewind_sym got %b exp 010", dut_sym); end
        vec++; if (head_pos !== 4'd0) begin errs++; $display("FAIL rewind_head got %0d exp 0", head_pos); end
        // Walk right rewriting the same symbols to read cells 1 and 2.
        issue(0, 1, 0, 3'b010, 1, 3'b001);
        vec++; if (dut_sym !== 3'b100) begin errs++; $display("FAIL cell1 got %b exp 100", dut_sym); end
        issue(0, 1, 0, 3'b100, 1, 3'b001);
        vec++; if (dut_sym !== 3'b001) begin errs++; $display("FAIL cell2 got %b exp 001", dut_sym); end
    endtask

    task automatic test_step_sequence();
        issue(1, 0, 0, 3'b001, 0, 3'b001);
        issue(0, 1, 0, 3'b010, 1, 3'b001);
        issue(0, 1, 0, 3'b100, 1, 3'b001);
        vec++; if (mid_head !== 4'd2) begin errs++; $display("FAIL step_head_mid got %0d exp 2", mid_head); end
        vec++; if (mid_ready !== 1'b0) begin errs++; $display("FAIL step_ready_mid got %b exp 0", mid_ready); end
        vec++; if (step_ready !== 1'b1) begin errs++; $display("FAIL step_ready_after got %b exp 1", step_ready); end
        vec++; if (mid_sym !== m_prev_sym) begin errs++; $display("FAIL sym_stable_settle got %b exp %b", mid_sym, m_prev_sym); end
        issue(0, 1, 0, 3'b001, 0, 3'b001);
        vec++; if (dut_sym !== 3'b100) begin errs++; $display("FAIL readback_s2 got %b exp 100", dut_sym); end
        vec++; if (head_pos !== 4'd1) begin errs++; $display("FAIL readback_head got %0d exp 1", head_pos); end
    endtask

    task automatic test_priority();
        issue(1, 0, 0, 3'b001, 0, 3'b001);
        for (int i = 0; i < 5; i++) issue(0, 0, 1, 3'b001, 0, 3'b001);
        issue(0, 1, 1, 3'b010, 0, 3'b100);
        vec++; if (head_pos !== 4'd4) begin errs++; $display("FAIL prio_head got %0d exp 4", head_pos); end
        issue(0, 1, 0, 3'b001, 1, 3'b001);
        vec++; if (dut_sym !== 3'b010) begin errs++; $display("FAIL prio_cell5 got %b exp 010", dut_sym); end
        vec++; if (fault !== 1'b0) begin errs++; $display("FAIL prio_fault got %b exp 0", fault); end
        // rewind beats step: no write at cell 5, head goes home
        issue(1, 1, 0, 3'b100, 1, 3'b001);
        vec++; if (head_pos !== 4'd0) begin errs++; $display("FAIL rewind_prio_head got %0d exp 0", head_pos); end
    endtask

    task automatic test_left_edge();
        issue(0, 1, 0, 3'b010, 0, 3'b001);
        vec++; if (mid_fault !== 1'b1) begin errs++; $display("FAIL ledge_fault got %b exp 1", mid_fault); end
        vec++; if (head_pos !== 4'd0) begin errs++; $display("FAIL ledge_head got %0d exp 0", head_pos); end
        vec++; if (dut_sym !== 3'b010) begin errs++; $display("FAIL ledge_sym got %b exp 010", dut_sym); end
        issue(1, 0, 0, 3'b001, 0, 3'b001);
        vec++; if (fault !== 1'b1) begin errs++; $display("FAIL fault_sticky got %b exp 1", fault); end
    endtask

    task automatic test_reset_mid_settle();
        @(negedge clk); step_valid = 1; write_sym = 3'b100; direction = 1;
        @(posedge clk); #1; step_valid = 0;
        #2 rst_n = 1'b0; m_reset();
        #1;
        vec++; if (step_ready !== 1'b1) begin errs++; $display("FAIL arst_ready got %b exp 1", step_ready); end
        vec++; if (head_pos !== 4'd0) begin errs++; $display("FAIL arst_head got %0d exp 0", head_pos); end
        vec++; if (dut_sym !== 3'b001) begin errs++; $display("FAIL arst_sym got %b exp 001", dut_sym); end
        vec++; if (fault !== 1'b0) begin errs++; $display("FAIL arst_fault got %b exp 0", fault); end
        @(negedge clk); rst_n = 1'b1;
        // A write whose edge is pre-empted by reset must not land.
        @(negedge clk); step_valid = 1; write_sym = 3'b010; direction = 1;
        #2 rst_n = 1'b0;
        #1 step_valid = 0;
        @(negedge clk); rst_n = 1'b1;
        issue(1, 0, 0, 3'b001, 0, 3'b001);
        vec++; if (dut_sym !== 3'b001) begin errs++; $display("FAIL inflight_discard got %b exp 001", dut_sym); end
    endtask

    task automatic test_invalid_sym();
        do_reset();
        issue(0, 0, 1, 3'b001, 0, 3'b100);
        issue(0, 1, 0, 3'b100, 0, 3'b001);
        vec++; if (dut_sym !== 3'b100) begin errs++; $display("FAIL inv_pre got %b exp 100", dut_sym); end
        issue(0, 1, 0, 3'b011, 1, 3'b001);
        vec++; if (mid_fault !== 1'b1) begin errs++; $display("FAIL inv_fault got %b exp 1", mid_fault); end
        issue(0, 1, 0, 3'b001, 0, 3'b001);
        vec++; if (dut_sym !== 3'b001) begin errs++; $display("FAIL inv_stored got %b exp 001", dut_sym); end
    endtask

    task automatic test_right_edge();
        do_reset();
        for (int i = 0; i < N - 1; i++) issue(0, 0, 1, 3'b001, 0, 3'b010);
        vec++; if ({at_left, at_right} !== 2'b01) begin errs++; $display("FAIL redge_flags got %b exp 01", {at_left, at_right}); end
        vec++; if (fault !== 1'b0) begin errs++; $display("FAIL redge_prefault got %b exp 0", fault); end
        issue(0, 0, 1, 3'b001, 0, 3'b100);
        vec++; if (head_pos !== 4'(N - 1)) begin errs++; $display("FAIL redge_head got %0d exp %0d", head_pos, N - 1); end
        vec++; if (fault !== 1'b1) begin errs++; $display("FAIL redge_fault got %b exp 1", fault); end
        vec++; if (dut_sym !== 3'b100) begin errs++; $display("FAIL redge_sym got %b exp 100", dut_sym); end
    endtask

    task automatic test_random();
        logic [2:0] ws, ls;
        bit rw, sv, lv, dir;
        do_reset();
        for (int n = 0; n < 80; n++) begin
            rw  = ($urandom % 8) == 0;
            sv  = $urandom % 2;
            lv  = $urandom % 2;
            dir = $urandom % 2;
            ws  = ($urandom % 8 < 7) ? 3'(1 << ($urandom % 3)) : 3'($urandom);
            ls  = ($urandom % 8 < 7) ? 3'(1 << ($urandom % 3)) : 3'($urandom);
            issue(rw, sv, lv, ws, dir, ls);
            vec++; if (mid_ready !== !m_acc) begin errs++; $display("FAIL rnd%0d_ready got %b exp %b", n, mid_ready, !m_acc); end
            vec++; if (mid_head !== 4'(m_head)) begin errs++; $display("FAIL rnd%0d_head got %0d exp %0d", n, mid_head, m_head); end
            vec++; if (mid_sym !== m_prev_sym) begin errs++; $display("FAIL rnd%0d_stable got %b exp %b", n, mid_sym, m_prev_sym); end
            vec++; if (dut_sym !== m_sym) begin errs++; $display("FAIL rnd%0d_sym got %b exp %b", n, dut_sym, m_sym); end
            vec++; if (fault !== m_fault) begin errs++; $display("FAIL rnd%0d_fault got %b exp %b", n, fault, m_fault); end
            vec++; if ({at_left, at_right} !== {m_head == 0, m_head == N - 1}) begin
                errs++; $display("FAIL rnd%0d_edges got %b exp %b", n, {at_left, at_right}, {m_head == 0, m_head == N - 1});
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        m_reset();
        test_reset();
        test_load_rewind();
        test_step_sequence();
        test_priority();
        test_left_edge();
        test_reset_mid_settle();
        test_invalid_sym();
        test_right_edge();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
